// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path: FSM states and BCD constants.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'h9;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] fixed
);

  assign fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with a held result register and saturating overflow flag.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned BW    = DIGITS * 4;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BW-1:0]    ALL_NINES = {DIGITS{BCD_NINE}};

  state_e            state;
  // Top bit is the sticky overflow capture; the rest are the BCD digits.
  logic [BW:0]       scratch;
  logic [IN_W-1:0]   shreg;
  logic [CNT_W-1:0]  cnt;
  logic [BW-1:0]     corr;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit (scratch[4*g +: 4]),
      .fixed (corr[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      scratch <= '0;
      shreg   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= CNT_LOAD;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Bit leaving the top digit is OR'd into the sticky overflow bit.
          scratch <= {scratch[BW] | corr[BW-1], corr[BW-2:0], shreg[IN_W-1]};
          shreg   <= {shreg[IN_W-2:0], 1'b0};
          cnt     <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (scratch[BW]) begin
            bcd <= ALL_NINES;
            ovf <= 1'b1;
          end else begin
            bcd <= scratch[BW-1:0];
            ovf <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 3-digit and a 2-digit instance checked
// against an arithmetic decimal model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start3 = 1'b0, start2 = 1'b0;
  logic [7:0]  bin3 = '0, bin2 = '0;
  logic        busy3, done3, ovf3, busy2, done2, ovf2;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q3[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq #(.IN_W(8), .DIGITS(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start3),
    .bin   (bin3),
    .busy  (busy3),
    .done  (done3),
    .bcd   (bcd3),
    .ovf   (ovf3)
  );

  bin2bcd_seq #(.IN_W(8), .DIGITS(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .bin   (bin2),
    .busy  (busy2),
    .done  (done2),
    .bcd   (bcd2),
    .ovf   (ovf2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal reference: digits by division, saturate to all nines when too large.
  function automatic exp_t model(input int v, input int digits, input int acc);
    exp_t e;
    int   rem;
    rem    = v;
    e.bcd  = '0;
    e.acc  = acc;
    e.ovf  = (v >= 10 ** digits);
    for (int i = 0; i < digits; i++) begin
      e.bcd = e.bcd | 12'((e.ovf ? 9 : rem % 10) << (4 * i));
      rem   = rem / 10;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on each done, otherwise checks results are held.
  initial begin
    logic [11:0] p3;
    logic [7:0]  p2;
    logic        p3o, p2o;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_busy3", busy3, 0);
        check("rst_done3", done3, 0);
        check("rst_bcd3", bcd3, 0);
        check("rst_ovf3", ovf3, 0);
        check("rst_busy2", busy2, 0);
        check("rst_done2", done2, 0);
        check("rst_bcd2", bcd2, 0);
      end else begin
        if (done3) begin
          if (q3.size() == 0) check("done3_unexpected", q3.size(), 1);
          else begin
            e = q3.pop_front();
            check("bcd3", bcd3, e.bcd);
            check("ovf3", ovf3, e.ovf);
            check("latency3", cyc - e.acc, 9);
          end
        end else begin
          check("hold_bcd3", bcd3, p3);
          check("hold_ovf3", ovf3, p3o);
        end
        if (done2) begin
          if (q2.size() == 0) check("done2_unexpected", q2.size(), 1);
          else begin
            e = q2.pop_front();
            check("bcd2", bcd2, e.bcd);
            check("ovf2", ovf2, e.ovf);
            check("latency2", cyc - e.acc, 9);
          end
        end else begin
          check("hold_bcd2", bcd2, p2);
          check("hold_ovf2", ovf2, p2o);
        end
      end
      p3  = bcd3;
      p3o = ovf3;
      p2  = bcd2;
      p2o = ovf2;
    end
  end

  task automatic issue(input int which, input int v);
    if (which == 3) begin
      bin3   = 8'(v);
      start3 = 1'b1;
      q3.push_back(model(v, 3, cyc + 1));
    end else begin
      bin2   = 8'(v);
      start2 = 1'b1;
      q2.push_back(model(v, 2, cyc + 1));
    end
    @(negedge clk);
    start3 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int n = 0;
    while (((which == 3) ? busy3 : busy2) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("idle_timeout", n, 0);
  endtask

  task automatic wait_done(input int which);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((which == 3) ? done3 : done2) && n < 30);
    if (!((which == 3) ? done3 : done2)) check("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    // Reset held with start asserted.
    start3 = 1'b1;
    start2 = 1'b1;
    bin3   = 8'd55;
    bin2   = 8'd55;
    repeat (4) @(negedge clk);
    start3 = 1'b0;
    start2 = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Zero, with busy length measured.
    wait_idle(3);
    issue(3, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy3) n++;
      @(negedge clk);
    end
    check("busy_cycles", n, 9);

    // 255 then 99 started in the done cycle.
    wait_idle(3);
    issue(3, 255);
    wait_done(3);
    bin3   = 8'd99;
    start3 = 1'b1;
    q3.push_back(model(99, 3, cyc + 1));
    @(negedge clk);
    start3 = 1'b0;
    wait_done(3);

    // Start held through a conversion while bin changes mid-flight.
    wait_idle(3);
    bin3   = 8'd7;
    start3 = 1'b1;
    q3.push_back(model(7, 3, cyc + 1));
    repeat (4) @(negedge clk);
    bin3 = 8'd200;
    wait_done(3);
    q3.push_back(model(200, 3, cyc + 1));
    @(negedge clk);
    start3 = 1'b0;
    wait_done(3);

    // Two-digit instance: overflow then recovery, then random values.
    wait_idle(2);
    issue(2, 150);
    wait_done(2);
    issue(2, 42);
    wait_done(2);
    for (int i = 0; i < 10; i++) begin
      wait_idle(2);
      issue(2, $urandom_range(0, 255));
    end

    // Randomized traffic with gaps, bin churn and ignored starts while busy.
    for (int i = 0; i < 25; i++) begin
      int unsigned v;
      int unsigned gap;
      v   = $urandom_range(0, 255);
      gap = $urandom_range(0, 3);
      wait_idle(3);
      repeat (gap) @(negedge clk);
      issue(3, v);
      bin3 = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        if (busy3) begin
          start3 = 1'b1;
          @(negedge clk);
          start3 = 1'b0;
        end
      end
    end

    n = 0;
    while ((q3.size() != 0 || q2.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", q3.size() + q2.size(), 0);

    // Abort 123 mid-conversion via reset.
    wait_idle(3);
    wait_idle(2);
    issue(3, 123);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy3, 0);
    check("abort_bcd", bcd3, 0);
    check("abort_ovf", ovf3, 0);
    check("abort_done", done3, 0);
    q3.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done3) n++;
    end
    check("done_after_abort", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
